oam_dma: RTL and testbench

//  Sprite DMA engine at $4014, on the CPU side of the system bus, downstream of the cpu address/data/write outputs.
//  A CPU write to $4014 halts the CPU through its ready input, then copies 256 bytes from page $XX00-$XXFF to $2004 (PPU OAMDATA).

---
 rtl/nes_pkg.sv | 15 +
 rtl/oam_dma.sv | 95 +++++++++
 tb/tb_oam_dma.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/nes_pkg.sv
// Shared NES bus definitions: sprite DMA state encoding and fixed register addresses.
package nes_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
    localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA engine: a CPU write to $4014 halts the CPU and copies page $XX00-$XXFF to OAMDATA.
// Build option: define OAM_DMA_ALIGN_EN to insert the 2A03 odd-cycle ALIGN stall.
module oam_dma
    import nes_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = ADDR_OAMDMA,
    parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_d_out,
    input  logic [7:0]  bus_d_in,
    output logic        cpu_ready,
    output logic        dma_active,
    output logic [15:0] bus_addr,
    output logic        bus_write,
    output logic [7:0]  bus_d_out
);

`ifdef OAM_DMA_ALIGN_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t state;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] data;
    logic       par;
    logic       trigger;

    // cpu_ready is a level, not a handshake: while it is low the CPU holds
    // its bus cycle and this block owns addr/write/data outright.
    assign trigger    = cpu_write && (cpu_addr == DMA_REG_ADDR);
    assign cpu_ready  = (state == IDLE);
    assign dma_active = ~cpu_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            page  <= 8'h00;
            idx   <= 8'h00;
            data  <= 8'h00;
            par   <= 1'b0;
        end else begin
            par <= ~par;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        page  <= cpu_d_out;
                        idx   <= 8'h00;
                        state <= HALT;
                    end
                end
                HALT:  state <= (ALIGN_EN && par) ? ALIGN : READ;
                ALIGN: state <= READ;
                READ: begin
                    data  <= bus_d_in;
                    state <= WRITE;
                end
                WRITE: begin
                    // idx wraps inside the page; the page register is never bumped
                    idx   <= idx + 8'h01;
                    state <= (idx == LAST_IDX) ? IDLE : READ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus_addr  = {page, idx};
        bus_write = 1'b0;
        bus_d_out = data;
        case (state)
            IDLE: begin
                bus_addr  = cpu_addr;
                bus_write = cpu_write;
                bus_d_out = cpu_d_out;
            end
            WRITE: begin
                bus_addr  = OAM_DATA_ADDR;
                bus_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: random memory and CPU noise against a per-transfer bus trace model.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_write;
    logic [7:0]  cpu_d_out;
    logic [7:0]  bus_d_in;
    logic        cpu_ready;
    logic        dma_active;
    logic [15:0] bus_addr;
    logic        bus_write;
    logic [7:0]  bus_d_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mem [0:65535];
    logic [24:0] exp_q[$];
    int          edges = 0;

`ifdef OAM_DMA_ALIGN_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    oam_dma dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_write  (cpu_write),
        .cpu_d_out  (cpu_d_out),
        .bus_d_in   (bus_d_in),
        .cpu_ready  (cpu_ready),
        .dma_active (dma_active),
        .bus_addr   (bus_addr),
        .bus_write  (bus_write),
        .bus_d_out  (bus_d_out)
    );

    always #5 clk = ~clk;

    assign bus_d_in = mem[bus_addr];

    // Edges since the last reset edge; its LSB is the parity the DUT should hold.
    always @(posedge clk) edges <= reset ? 0 : edges + 1;

    task automatic step_drive(input logic [15:0] a, input logic w, input logic [7:0] d);
        @(posedge clk);
        #1;
        cpu_addr  = a;
        cpu_write = w;
        cpu_d_out = d;
        #1;
    endtask

    task automatic step_noise();
        logic [15:0] a;
        a = 16'($urandom_range(0, 16'hFFFF));
        if (a == 16'h4014) a = 16'h0000;
        step_drive(a, 1'($urandom_range(0, 1)), 8'($urandom));
    endtask

    // One full transfer. want_par: -1 any, else required parity in the HALT cycle.
    // inject_at: transfer cycle at which to drive a stray $4014 write (-1 none).
    task automatic run_xfer(input logic [7:0] page, input int want_par, input int inject_at,
                            input string tag);
        int halt_par;
        int n_dead;
        int low_cnt;
        int exp_low;
        logic [24:0] e;
        if (want_par >= 0 && ((edges + 1) % 2) != want_par) step_noise();
        step_drive(16'h4014, 1'b1, page);
        n_cmp++;
        if (bus_addr !== 16'h4014 || bus_write !== 1'b1 || bus_d_out !== page || cpu_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s trigger_passthrough: addr=%h wr=%b d=%h rdy=%b want 4014/1/%h/1",
                     tag, bus_addr, bus_write, bus_d_out, cpu_ready, page);
        end
        halt_par = (edges + 1) % 2;
        n_dead = 1 + ((ALIGN_ON && halt_par == 1) ? 1 : 0);
        exp_low = n_dead + 512;
        exp_q.delete();
        for (int k = 0; k < n_dead; k++) exp_q.push_back({page, 8'h00, 1'b0, 8'h00});
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back({page, 8'(i), 1'b0, 8'h00});
            exp_q.push_back({16'h2004, 1'b1, mem[{page, 8'(i)}]});
        end
        low_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            if (c == inject_at) step_drive(16'h4014, 1'b1, 8'h07);
            else step_noise();
            if (cpu_ready === 1'b1) break;
            low_cnt++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 25'h0;
            n_cmp++;
            if (dma_active !== 1'b1 || bus_addr !== e[24:9] || bus_write !== e[8] ||
                (e[8] && bus_d_out !== e[7:0])) begin
                n_bad++;
                $display("FAIL %s cycle%0d: act=%b/%h/%b/%h want=1/%h/%b/%h",
                         tag, c, dma_active, bus_addr, bus_write, bus_d_out, e[24:9], e[8], e[7:0]);
            end
        end
        n_cmp++;
        if (low_cnt !== exp_low || exp_q.size() != 0 || cpu_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ready_low: got %0d cycles (left %0d, rdy=%b) want %0d",
                     tag, low_cnt, exp_q.size(), cpu_ready, exp_low);
        end
        n_cmp++;
        if (bus_addr !== cpu_addr || bus_write !== cpu_write || bus_d_out !== cpu_d_out || dma_active !== 1'b0) begin
            n_bad++;
            $display("FAIL %s post_idle: addr=%h wr=%b d=%h act=%b want %h/%b/%h/0",
                     tag, bus_addr, bus_write, bus_d_out, dma_active, cpu_addr, cpu_write, cpu_d_out);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step_drive(16'h1234, 1'b1, 8'h5A);
        step_drive(16'h1234, 1'b1, 8'h5A);
        n_cmp++;
        if (bus_addr !== 16'h1234 || bus_write !== 1'b1 || bus_d_out !== 8'h5A ||
            cpu_ready !== 1'b1 || dma_active !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: addr=%h wr=%b d=%h rdy=%b act=%b want 1234/1/5a/1/0",
                     bus_addr, bus_write, bus_d_out, cpu_ready, dma_active);
        end
        reset = 1'b0;
        step_drive(16'h1234, 1'b1, 8'h5A);
        n_cmp++;
        if (bus_addr !== 16'h1234 || bus_d_out !== 8'h5A || cpu_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_passthrough: addr=%h d=%h rdy=%b want 1234/5a/1", bus_addr, bus_d_out, cpu_ready);
        end
    endtask

    task automatic test_basic();
        run_xfer(8'h02, 0, -1, "page02_even");
    endtask

    task automatic test_parity();
        run_xfer(8'($urandom_range(0, 255)), 1, -1, "odd_par");
        run_xfer(8'($urandom_range(0, 255)), 0, -1, "even_par");
    endtask

    task automatic test_page_ff();
        run_xfer(8'hFF, -1, -1, "page_ff");
    endtask

    task automatic test_reset_mid();
        int writes = 0;
        bit hit = 1'b0;
        step_drive(16'h4014, 1'b1, 8'h03);
        for (int c = 0; c < 600; c++) begin
            step_noise();
            if (bus_write === 1'b1 && bus_addr === 16'h2004 && dma_active === 1'b1) begin
                if (writes == 8'h40) begin
                    hit = 1'b1;
                    break;
                end
                writes++;
            end
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL reset_mid_reach: saw %0d writes want idx 64 reached", writes);
        end
        reset = 1'b1;
        step_drive(16'hABCD, 1'b0, 8'h3C);
        n_cmp++;
        if (cpu_ready !== 1'b1 || dma_active !== 1'b0 || bus_addr !== 16'hABCD ||
            bus_write !== 1'b0 || bus_d_out !== 8'h3C) begin
            n_bad++;
            $display("FAIL reset_mid_abort: rdy=%b act=%b addr=%h wr=%b d=%h want 1/0/abcd/0/3c",
                     cpu_ready, dma_active, bus_addr, bus_write, bus_d_out);
        end
        reset = 1'b0;
        run_xfer(8'($urandom_range(0, 255)), -1, -1, "restart");
    endtask

    task automatic test_ignore_retrigger();
        run_xfer(8'h11, -1, 100, "retrigger");
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 3; t++) run_xfer(8'($urandom_range(0, 255)), -1, -1, "b2b");
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        reset = 1'b1;
        cpu_addr = 16'h0000;
        cpu_write = 1'b0;
        cpu_d_out = 8'h00;
        test_reset();
        test_basic();
        test_parity();
        test_page_ff();
        test_reset_mid();
        test_ignore_retrigger();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
